// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
//   SPI mode-0 transmitter. Serialises an N-bit word MSB first onto MOSI/SCK
//   and frames it for a SCK-clocked receiver:
//     pulse 0      : spi_start high, MOSI low (receiver start/reset pulse)
//     pulse 1..N   : data bits, MSB first
//     pulse N+1,N+2: flush pulses, MOSI low
//   SCK is a registered, divided copy of clk (CLK_DIV clk cycles per half).
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   start      in   transfer request, sampled only in IDLE
//   data_in    in   N-bit word, captured when start is accepted
//   MOSI       out  serial data, changes only when SCK falls (or at accept)
//   SCK        out  serial clock, idles low
//   spi_start  out  receiver start strobe, high for SCK pulse 0 only
//   busy       out  high from the cycle after accept until done
//   done       out  one-cycle completion pulse
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | SCK low, waiting for start
// LOW    | SCK low half-period, MOSI/spi_start already set up
// HIGH   | SCK high half-period; on its last cycle set up the next pulse
// DONE   | done pulse, busy low, back to IDLE next cycle
// -----------------------------------------------------------------------------
module spi_master #(
  parameter int N       = 8,
  parameter int CLK_DIV = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] data_in,
  output logic         MOSI,
  output logic         SCK,
  output logic         spi_start,
  output logic         busy,
  output logic         done
);

  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam int PW = $clog2(N + 3);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_t;

  state_t         state_q;
  logic [DW-1:0]  div_q;
  logic [PW-1:0]  pulse_q;
  logic [N-1:0]   shift_q;
  logic           mosi_q;
  logic           sck_q;
  logic           sst_q;
  logic           busy_q;
  logic           done_q;

  logic [DW-1:0]  div_d;
  logic [PW-1:0]  pulse_d;
  logic           div_tc;

  assign div_d   = div_q + 1'b1;
  assign pulse_d = pulse_q + 1'b1;
  assign div_tc  = (div_q == DW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      pulse_q <= '0;
      shift_q <= '0;
      mosi_q  <= 1'b0;
      sck_q   <= 1'b0;
      sst_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          sck_q  <= 1'b0;
          done_q <= 1'b0;
          if (start) begin
            shift_q <= data_in;
            busy_q  <= 1'b1;
            sst_q   <= 1'b1;
            mosi_q  <= 1'b0;
            div_q   <= '0;
            pulse_q <= '0;
            state_q <= S_LOW;
          end
        end

        S_LOW: begin
          if (div_tc) begin
            sck_q   <= 1'b1;
            div_q   <= '0;
            state_q <= S_HIGH;
          end else begin
            div_q <= div_d;
          end
        end

        S_HIGH: begin
          if (div_tc) begin
            sck_q   <= 1'b0;
            div_q   <= '0;
            pulse_q <= pulse_d;
            sst_q   <= 1'b0;
            if (pulse_q == PW'(N + 2)) begin
              mosi_q  <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_LOW;
              // next pulse k = pulse_q+1 carries data for k in 1..N
              if (pulse_q < PW'(N)) begin
                mosi_q  <= shift_q[N-1];
                shift_q <= {shift_q[N-2:0], 1'b0};
              end else begin
                mosi_q <= 1'b0;
              end
            end
          end else begin
            div_q <= div_d;
          end
        end

        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign MOSI      = mosi_q;
  assign SCK       = sck_q;
  assign spi_start = sst_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
